// File: rtl/dm_mbox_slv_if.sv
// DM slave bus plus host byte-stream ports of the dm_mbox_slv mailbox.
// Signal prefixes are from the slave's point of view.
interface dm_mbox_slv_if;
   logic        i_sel;
   logic [15:0] i_ramadr;
   logic [7:0]  i_ramdout;
   logic        i_ramre;
   logic        i_ramwe;
   logic        o_out_en;
   logic        o_wait;
   logic [7:0]  o_ramdin;
   logic [7:0]  i_host_rx_data;
   logic        i_host_rx_valid;
   logic        o_host_rx_ready;
   logic [7:0]  o_host_tx_data;
   logic        o_host_tx_valid;
   logic        i_host_tx_ready;
   logic        o_irq;

   modport slave (
      input  i_sel, i_ramadr, i_ramdout, i_ramre, i_ramwe,
      input  i_host_rx_data, i_host_rx_valid, i_host_tx_ready,
      output o_out_en, o_wait, o_ramdin,
      output o_host_rx_ready, o_host_tx_data, o_host_tx_valid, o_irq
   );

   modport master (
      output i_sel, i_ramadr, i_ramdout, i_ramre, i_ramwe,
      output i_host_rx_data, i_host_rx_valid, i_host_tx_ready,
      input  o_out_en, o_wait, o_ramdin,
      input  o_host_rx_ready, o_host_tx_data, o_host_tx_valid, o_irq
   );
endinterface

// File: rtl/dm_mbox_slv.sv
// AVR DM-bus mailbox slave: RX/TX byte FIFOs to a host port, 4-byte register window.
// Define DM_MBOX_IRQ_EN to implement CTRL interrupt enables and the registered irq output.
module dm_mbox_slv #(
   parameter logic [15:0] base_adr        = 16'h1000,
   parameter int unsigned fifo_depth_log2 = 4,
   parameter int unsigned rd_ws           = 1
) (
   input logic          i_cp2,
   input logic          i_ireset,
   dm_mbox_slv_if.slave bus
);

   localparam int unsigned DEPTH = 1 << fifo_depth_log2;
   localparam int unsigned CNT_W = fifo_depth_log2 + 1;
   localparam int unsigned PTR_W = fifo_depth_log2;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RXCNT  = 2'd3
   } reg_e;

   logic             w_hit, w_rd_hit, w_wr_hit, w_wait, w_rd_done;
   reg_e             w_reg;
   logic             w_ctrl_wr, w_rx_flush, w_tx_flush;
   logic             w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
   logic             w_rx_nempty, w_rx_full, w_tx_nempty, w_tx_full;
   logic             w_rx_ie, w_txe_ie;
   logic [7:0]       w_rdata;

   logic [2:0]       r_ws_cnt;
   logic [7:0]       r_rx_mem [DEPTH];
   logic [7:0]       r_tx_mem [DEPTH];
   logic [PTR_W-1:0] r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
   logic [CNT_W-1:0] r_rx_cnt, r_tx_cnt;
   logic             r_rx_unf, r_tx_ovf;

   assign w_hit     = bus.i_sel & (bus.i_ramadr[15:2] == base_adr[15:2]);
   assign w_reg     = reg_e'(bus.i_ramadr[1:0]);
   assign w_rd_hit  = bus.i_ramre & w_hit;
   assign w_wr_hit  = bus.i_ramwe & w_hit;
   assign w_wait    = w_rd_hit & (w_reg == REG_DATA) & (r_ws_cnt != 3'(rd_ws));
   assign w_rd_done = w_rd_hit & ~w_wait;

   assign w_rx_nempty = (r_rx_cnt != '0);
   assign w_rx_full   = (r_rx_cnt == FULL_CNT);
   assign w_tx_nempty = (r_tx_cnt != '0);
   assign w_tx_full   = (r_tx_cnt == FULL_CNT);

   assign w_ctrl_wr  = w_wr_hit & (w_reg == REG_CTRL);
   assign w_rx_flush = w_ctrl_wr & bus.i_ramdout[6];
   assign w_tx_flush = w_ctrl_wr & bus.i_ramdout[7];

   assign w_rx_push = bus.i_host_rx_valid & ~w_rx_full;
   assign w_rx_pop  = w_rd_done & (w_reg == REG_DATA) & w_rx_nempty;
   assign w_tx_push = w_wr_hit & (w_reg == REG_DATA) & ~w_tx_full;
   assign w_tx_pop  = w_tx_nempty & bus.i_host_tx_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_cp2) begin
      if (i_ireset)    r_ws_cnt <= '0;
      else if (w_wait) r_ws_cnt <= r_ws_cnt + 3'd1;
      else             r_ws_cnt <= '0;
   end

   // Flush has priority over any push or pop in the same cycle.
   always_ff @(posedge i_cp2) begin
      if (i_ireset || w_rx_flush) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
         if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + CNT_ONE;
         else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge i_cp2) begin
      if (i_ireset || w_tx_flush) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
         if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + CNT_ONE;
         else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - CNT_ONE;
      end
   end

   // NOTE: storage arrays carry no reset; counts and pointers alone define validity.
   always_ff @(posedge i_cp2) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.i_host_rx_data;
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.i_ramdout;
   end

   // A new error event in the same cycle as its W1C write keeps the flag set.
   always_ff @(posedge i_cp2) begin
      if (i_ireset) begin
         r_rx_unf <= 1'b0;
         r_tx_ovf <= 1'b0;
      end else begin
         if (w_wr_hit && w_reg == REG_STATUS && bus.i_ramdout[4]) r_rx_unf <= 1'b0;
         if (w_wr_hit && w_reg == REG_STATUS && bus.i_ramdout[5]) r_tx_ovf <= 1'b0;
         if (w_rd_done && w_reg == REG_DATA && !w_rx_nempty)      r_rx_unf <= 1'b1;
         if (w_wr_hit && w_reg == REG_DATA && w_tx_full)          r_tx_ovf <= 1'b1;
      end
   end

`ifdef DM_MBOX_IRQ_EN
   logic r_rx_ie, r_txe_ie, r_irq;

   always_ff @(posedge i_cp2) begin
      if (i_ireset) begin
         r_rx_ie  <= 1'b0;
         r_txe_ie <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_rx_ie  <= bus.i_ramdout[0];
            r_txe_ie <= bus.i_ramdout[1];
         end
         r_irq <= (r_rx_ie & w_rx_nempty) | (r_txe_ie & ~w_tx_nempty);
      end
   end

   assign w_rx_ie   = r_rx_ie;
   assign w_txe_ie  = r_txe_ie;
   assign bus.o_irq = r_irq;
`else
   assign w_rx_ie   = 1'b0;
   assign w_txe_ie  = 1'b0;
   assign bus.o_irq = 1'b0;
`endif

   // NOTE: always_comb assigns a default first so no path can infer a latch.
   always_comb begin
      w_rdata = 8'h00;
      if (w_rd_hit) begin
         case (w_reg)
            REG_DATA:   w_rdata = w_rx_nempty ? r_rx_mem[r_rx_rptr] : 8'h00;
            REG_STATUS: w_rdata = {2'b00, r_tx_ovf, r_rx_unf,
                                   w_tx_full, w_tx_nempty, w_rx_full, w_rx_nempty};
            REG_CTRL:   w_rdata = {6'b000000, w_txe_ie, w_rx_ie};
            REG_RXCNT:  w_rdata = 8'(r_rx_cnt);
            default:    w_rdata = 8'h00;
         endcase
      end
   end

   assign bus.o_out_en        = w_rd_hit;
   assign bus.o_wait          = w_wait;
   assign bus.o_ramdin        = w_rdata;
   assign bus.o_host_rx_ready = ~w_rx_full;
   assign bus.o_host_tx_valid = w_tx_nempty;
   assign bus.o_host_tx_data  = w_tx_nempty ? r_tx_mem[r_tx_rptr] : 8'h00;

endmodule
